// File: rtl/ddr3_rst_pkg.sv
// Shared definitions for the DDR3 clock-domain reset sequencing logic.
package ddr3_rst_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        REL_PHY,
        REL_CTRL,
        RUN
    } seq_state_e;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Generic multi-flop synchronizer for a single asynchronous level signal.
module lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL RESET pin and releases PHY/controller/user resets in order
// once the synchronized PLL lock has been stable.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RST   | pll_reset asserted, all domain resets held
// WAIT_LOCK | counting stable lock cycles, retry PLL on timeout
// REL_PHY   | PHY reset released, waiting one stage gap
// REL_CTRL  | controller reset released, waiting one stage gap
// RUN       | all resets released, ready high
module pll_reset_sequencer
    import ddr3_rst_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 2048,
    parameter int STAGE_GAP_CYCLES    = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock,
    output logic               pll_reset,
    output logic               rst_phy,
    output logic               rst_ctrl,
    output logic               rst_user,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int TMR_MAX  = (PLL_RST_CYCLES > STAGE_GAP_CYCLES) ? PLL_RST_CYCLES : STAGE_GAP_CYCLES;
    localparam int TMR_W    = cnt_width(TMR_MAX);
    localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMO_W    = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [TMR_W-1:0]    PLL_LOAD   = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]    PLL_START  = TMR_W'(PLL_RST_CYCLES);
    localparam logic [TMR_W-1:0]    GAP_LOAD   = TMR_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_TC  = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic lock_s;

    lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (lock),
        .dout (lock_s)
    );

    seq_state_e          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [TMO_W-1:0]    timeout_q, timeout_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                pll_reset_q, pll_reset_d;
    logic                rst_phy_q, rst_phy_d;
    logic                rst_ctrl_q, rst_ctrl_d;
    logic                rst_user_q, rst_user_d;
    logic                ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        stable_d  = '0;
        timeout_d = '0;
        retry_d   = retry_q;

        case (state_q)
            PLL_RST: begin
                if (tmr_q == '0) begin
                    state_d = WAIT_LOCK;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            WAIT_LOCK: begin
                stable_d  = lock_s ? stable_q + STABLE_W'(1) : '0;
                timeout_d = timeout_q + TMO_W'(1);
                if (stable_q == STABLE_TC) begin
                    state_d   = REL_PHY;
                    tmr_d     = GAP_LOAD;
                    stable_d  = '0;
                    timeout_d = '0;
                // Retry period is exactly the pulse plus LOCK_TIMEOUT_CYCLES.
                end else if (timeout_q == TMO_LAST) begin
                    state_d   = PLL_RST;
                    tmr_d     = PLL_LOAD;
                    stable_d  = '0;
                    timeout_d = '0;
                    if (retry_q != '1) begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
            end
            REL_PHY, REL_CTRL: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (tmr_q == '0) begin
                    state_d = (state_q == REL_PHY) ? REL_CTRL : RUN;
                    tmr_d   = GAP_LOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = PLL_RST;
                tmr_d   = PLL_LOAD;
            end
        endcase

        pll_reset_d = (state_d == PLL_RST);
        rst_phy_d   = !(state_d inside {REL_PHY, REL_CTRL, RUN});
        rst_ctrl_d  = !(state_d inside {REL_CTRL, RUN});
        rst_user_d  = (state_d != RUN);
        ready_d     = (state_d == RUN);
    end

    // The first pulse is timed from the first edge with rst low, hence the longer load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PLL_RST;
            tmr_q       <= PLL_START;
            stable_q    <= '0;
            timeout_q   <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            rst_phy_q   <= 1'b1;
            rst_ctrl_q  <= 1'b1;
            rst_user_q  <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            stable_q    <= stable_d;
            timeout_q   <= timeout_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            rst_phy_q   <= rst_phy_d;
            rst_ctrl_q  <= rst_ctrl_d;
            rst_user_q  <= rst_user_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign rst_phy   = rst_phy_q;
    assign rst_ctrl  = rst_ctrl_q;
    assign rst_user  = rst_user_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues the expected output changes (edge number
// and value); the monitor pops one entry for every output change it observes.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       pll_reset;
    logic       rst_phy;
    logic       rst_ctrl;
    logic       rst_user;
    logic       ready;
    logic [3:0] retry_cnt;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .STAGE_GAP_CYCLES   (3),
        .LOCK_TIMEOUT_CYCLES(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock      (lock),
        .pll_reset (pll_reset),
        .rst_phy   (rst_phy),
        .rst_ctrl  (rst_ctrl),
        .rst_user  (rst_user),
        .ready     (ready),
        .retry_cnt (retry_cnt)
    );

    typedef struct {
        int         cyc;
        logic [8:0] val;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    logic [8:0] prev_v = 'x;
    logic [8:0] cur_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] mk(input bit p, input bit phy, input bit ctrl,
                                      input bit user, input bit rdy, input int r);
        return {p, phy, ctrl, user, rdy, 4'(r)};
    endfunction

    task automatic push(input int c, input logic [8:0] v, input string n);
        exp_t x;
        x.cyc  = c;
        x.val  = v;
        x.name = n;
        exp_q.push_back(x);
    endtask

    // Returns on the falling edge just before edge e, so a drive here is sampled at e.
    task automatic goto(input int e_cyc);
        do @(negedge clk); while (cyc < e_cyc - 1);
        if (cyc != e_cyc - 1) begin
            $display("FAIL goto: at cycle %0d, wanted %0d", cyc, e_cyc - 1);
            $fatal(1);
        end
    endtask

    always @(negedge clk) begin
        cur_v = {pll_reset, rst_phy, rst_ctrl, rst_user, ready, retry_cnt};
        if (cur_v !== prev_v) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: cycle %0d value %b, none required", cyc, cur_v);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== cur_v) begin
                    bad++;
                    $display("FAIL %s: got cycle %0d value %b, required cycle %0d value %b",
                             e.name, cyc, cur_v, e.cyc, e.val);
                end
            end
            prev_v = cur_v;
        end
        if (cyc >= 1) begin
            total++;
            if ((!rst_ctrl && rst_phy) || (!rst_user && rst_ctrl) || (ready !== !rst_user)) begin
                bad++;
                $display("FAIL ordering: cycle %0d phy=%b ctrl=%b user=%b ready=%b, required ordered release",
                         cyc, rst_phy, rst_ctrl, rst_user, ready);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: cycle %0d, required finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        lock = 1'b0;

        // Nominal bring-up: first edge with rst low is 4, lock sampled high at 14.
        push(1,  mk(1, 1, 1, 1, 0, 0), "reset_state");
        push(8,  mk(0, 1, 1, 1, 0, 0), "pll_pulse_end");
        push(24, mk(0, 0, 1, 1, 0, 0), "nom_phy");
        push(27, mk(0, 0, 0, 1, 0, 0), "nom_ctrl");
        push(30, mk(0, 0, 0, 0, 1, 0), "nom_user");
        goto(4);  rst  = 1'b0;
        goto(14); lock = 1'b1;

        // Lock loss in RUN, then restore.
        push(42, mk(0, 1, 1, 1, 0, 0), "run_loss");
        push(60, mk(0, 0, 1, 1, 0, 0), "relock_phy");
        push(63, mk(0, 0, 0, 1, 0, 0), "relock_ctrl");
        push(66, mk(0, 0, 0, 0, 1, 0), "relock_user");
        goto(40); lock = 1'b0;
        goto(50); lock = 1'b1;

        // One-cycle glitch during the stability count restarts it.
        push(78,  mk(0, 1, 1, 1, 0, 0), "glitch_pre_loss");
        push(102, mk(0, 0, 1, 1, 0, 0), "glitch_phy");
        push(105, mk(0, 0, 0, 1, 0, 0), "glitch_ctrl");
        push(108, mk(0, 0, 0, 0, 1, 0), "glitch_user");
        goto(76); lock = 1'b0;
        goto(86); lock = 1'b1;
        goto(91); lock = 1'b0;
        goto(92); lock = 1'b1;

        // Loss right after PHY release, then no lock: retries saturate at 15.
        push(117, mk(0, 1, 1, 1, 0, 0), "pre_loss");
        push(135, mk(0, 0, 1, 1, 0, 0), "early_phy");
        push(138, mk(0, 1, 1, 1, 0, 0), "early_loss");
        for (int n = 1; n <= 17; n++) begin
            push(170 + 36 * (n - 1),     mk(1, 1, 1, 1, 0, (n > 15) ? 15 : n), "retry_rise");
            push(170 + 36 * (n - 1) + 4, mk(0, 1, 1, 1, 0, (n > 15) ? 15 : n), "retry_fall");
        end
        goto(115); lock = 1'b0;
        goto(125); lock = 1'b1;
        goto(136); lock = 1'b0;

        // rst while in REL_PHY clears everything including retry_cnt.
        push(765, mk(0, 0, 1, 1, 0, 15), "pre_rst_phy");
        push(766, mk(1, 1, 1, 1, 0, 0),  "rst_mid");
        push(774, mk(0, 1, 1, 1, 0, 0),  "rst_pll_end");
        goto(755); lock = 1'b1;
        goto(766); rst  = 1'b1;
        goto(770); rst  = 1'b0;
        goto(780);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: %0d left, first %s at cycle %0d, required 0 left",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
